// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate plus register/opcode fields into an RV32I word,
// flags immediates that do not fit, and streams words with valid/ready and an address.
// Ports: clk, rst (sync, active-high), i_restart, i_valid/o_ready (input handshake),
//   i_imm, i_ImmSel, i_opcode, i_rd, i_funct3, i_rs1, i_rs2, i_funct7 (fields),
//   o_valid/i_ready (output handshake), o_instr, o_addr, o_err,
//   o_enc_cnt, o_err_cnt (statistics, built only with `define IMM_ENC_STAT_EN).
module imm_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_restart,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_imm,
  input  logic [2:0]        i_ImmSel,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [2:0]        i_funct3,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [6:0]        i_funct7,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [15:0]       o_enc_cnt,
  output logic [15:0]       o_err_cnt
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [31:0]       v;
  logic [31:0]       enc;
  logic              enc_err;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [ADDR_W-1:0] nxt_eff;
  logic              acc;
  logic              hs;

  assign v = i_imm;

  always_comb begin
    enc     = '0;
    enc_err = 1'b0;
    case (i_ImmSel)
      3'b000: begin
        enc = {v[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        enc_err = !((&v[31:11]) || !(|v[31:11]));
      end
      3'b001: begin
        enc = {v[11:5], i_rs2, i_rs1, i_funct3, v[4:0], i_opcode};
        enc_err = !((&v[31:11]) || !(|v[31:11]));
      end
      3'b010: begin
        enc = {v[12], v[10:5], i_rs2, i_rs1, i_funct3,
               v[4:1], v[11], i_opcode};
        enc_err = !((&v[31:12]) || !(|v[31:12])) || v[0];
      end
      3'b011: begin
        enc = {v[20], v[10:1], v[11], v[19:12], i_rd, i_opcode};
        enc_err = !((&v[31:20]) || !(|v[31:20])) || v[0];
      end
      3'b100: begin
        enc = {v[31:12], i_rd, i_opcode};
        enc_err = |v[11:0];
      end
      default: begin
        enc = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        enc_err = 1'b0;
      end
    endcase
  end

  assign o_ready = !valid_q || i_ready;
  assign acc     = i_valid && o_ready;
  assign hs      = valid_q && i_ready;

  // nxt_q is the address the next accepted word receives; a held word
  // keeps addr_q untouched, so a restart only affects later words.
  always_comb begin
    nxt_eff = i_restart ? BASE : nxt_q;
    valid_d = acc || (valid_q && !i_ready);
    instr_d = acc ? enc : instr_q;
    err_d   = acc ? enc_err : err_q;
    addr_d  = o_ready ? nxt_eff : addr_q;
    nxt_d   = acc ? nxt_eff + STEP : nxt_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE;
      nxt_q   <= BASE;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      nxt_q   <= nxt_d;
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_err   = err_q;
  assign o_addr  = addr_q;

`ifdef IMM_ENC_STAT_EN
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (hs && enc_cnt_q != 16'hFFFF) enc_cnt_d = enc_cnt_q + 16'd1;
    if (hs && err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_enc_cnt = enc_cnt_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_enc_cnt = 16'd0;
  assign o_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder; directed vectors,
// backpressure, restart/reset and randomized ImmGen round-trip.
module tb_imm_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_restart = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_imm = '0;
  logic [2:0]  i_ImmSel = '0;
  logic [6:0]  i_opcode = '0;
  logic [4:0]  i_rd = '0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rs1 = '0;
  logic [4:0]  i_rs2 = '0;
  logic [6:0]  i_funct7 = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_instr;
  logic [31:0] o_addr;
  logic        o_err;
  logic [15:0] o_enc_cnt;
  logic [15:0] o_err_cnt;

  imm_encoder #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .i_restart(i_restart),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_imm(i_imm), .i_ImmSel(i_ImmSel), .i_opcode(i_opcode),
    .i_rd(i_rd), .i_funct3(i_funct3), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct7(i_funct7),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_addr(o_addr), .o_err(o_err),
    .o_enc_cnt(o_enc_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] v;
    logic [31:0] ins;
    bit          full;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int prev_hs = 0;
  int n_hs = 0;
  int n_err_hs = 0;
  logic [31:0] mon_addr = BASE;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] immgen(input logic [2:0] s,
                                         input logic [31:0] x);
    case (s)
      3'd0: immgen = {{20{x[31]}}, x[31:20]};
      3'd1: immgen = {{20{x[31]}}, x[31:25], x[11:7]};
      3'd2: immgen = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd3: immgen = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      3'd4: immgen = {x[31:12], 12'h000};
      default: immgen = 32'h0;
    endcase
  endfunction

  function automatic logic fits(input logic [2:0] s, input logic [31:0] x);
    longint sv;
    sv = longint'($signed(x));
    case (s)
      3'd0, 3'd1: fits = sv >= -2048 && sv <= 2047;
      3'd2: fits = sv >= -4096 && sv <= 4095 && (sv % 2 == 0);
      3'd3: fits = sv >= -1048576 && sv <= 1048575 && (sv % 2 == 0);
      3'd4: fits = (x % 4096) == 0;
      default: fits = 1'b1;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      mon_addr = BASE;
      n_hs = 0;
      n_err_hs = 0;
    end else if (o_valid && i_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("addr", o_addr, mon_addr);
        chk("err", {31'd0, o_err}, {31'd0, e.err});
        if (e.full) chk("instr", o_instr, e.ins);
        else if (!e.err) chk("roundtrip", immgen(e.sel, o_instr), e.v);
      end
      n_hs++;
      if (o_err) n_err_hs++;
      prev_hs = last_hs;
      last_hs = cyc;
      mon_addr = i_restart ? BASE : mon_addr + 32'd4;
    end
  end

  task automatic send(input logic [2:0] sel, input logic [31:0] v,
                      input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [6:0] f7,
                      input bit full, input logic [31:0] ins,
                      input logic rs);
    exp_t e;
    bit done;
    i_ImmSel = sel; i_imm = v; i_opcode = op; i_rd = rd;
    i_funct3 = f3; i_rs1 = rs1; i_rs2 = rs2; i_funct7 = f7;
    i_restart = rs;
    i_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        e.sel = sel; e.v = v; e.ins = ins; e.full = full;
        e.err = !fits(sel, v);
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
    i_restart = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IMM_ENC_STAT_EN
    exp_cnt = n;
`else
    exp_cnt = 32'd0 + 0 * n;
`endif
  endfunction

  logic [31:0] held_i;
  logic [31:0] held_a;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_addr", o_addr, BASE);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_enc_cnt", {16'd0, o_enc_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // I-type addi x1,x2,-5 then check one-cycle latency
    send(3'd0, 32'hFFFF_FFFB, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0,
         1, 32'hFFB1_0093, 0);
    chk("i_latency", {31'd0, o_valid}, 32'd1);
    drain();

    // B-type in range, then misaligned
    send(3'd2, 32'd8, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0,
         1, 32'h0020_8463, 0);
    send(3'd2, 32'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0,
         1, 32'h0020_8163, 0);
    drain();
    chk("err_cnt", {16'd0, o_err_cnt}, exp_cnt(n_err_hs));
    chk("enc_cnt", {16'd0, o_enc_cnt}, exp_cnt(n_hs));

    // U then J back-to-back
    send(3'd4, 32'h1234_5000, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h1234_52B7, 0);
    send(3'd3, 32'd2048, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h0010_00EF, 0);
    drain();
    chk("uj_thru", last_hs - prev_hs, 32'd1);

    // R-type
    send(3'd5, 32'hDEAD_BEEF, 7'h33, 5'd3, 3'd0, 5'd4, 5'd5, 7'h20,
         1, 32'h4052_01B3, 0);
    drain();

    // backpressure: hold output 3 cycles with a second word pending
    i_ready = 1'b0;
    send(3'd0, 32'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h0070_0093, 0);
    fork
      send(3'd0, 32'd9, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0,
           1, 32'h0090_0113, 0);
      begin
        @(negedge clk);
        held_i = o_instr;
        held_a = o_addr;
        for (int k = 0; k < 3; k++) begin
          chk("bp_ready", {31'd0, o_ready}, 32'd0);
          chk("bp_instr", o_instr, held_i);
          chk("bp_addr", o_addr, held_a);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // restart coincident with an output handshake
    send(3'd0, 32'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h0010_0093, 0);
    send(3'd0, 32'd2, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h0020_0093, 1);
    @(negedge clk);
    chk("restart_addr", o_addr, BASE);
    drain();

    // reset while a word is held
    i_ready = 1'b0;
    send(3'd0, 32'd5, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0,
         1, 32'h0050_0093, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_addr", o_addr, BASE);
    chk("mid_rst_cnt", {16'd0, o_enc_cnt}, 32'd0);
    chk("mid_rst_ecnt", {16'd0, o_err_cnt}, 32'd0);
    sb.delete();
    rst = 1'b0;
    i_ready = 1'b1;

    // randomized round-trip, in range then arbitrary
    for (int s = 0; s < 5; s++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] v;
        case (s)
          0, 1: v = $urandom_range(0, 4095) - 32'd2048;
          2: v = ($urandom_range(0, 8191) - 32'd4096) & ~32'd1;
          3: v = ($urandom_range(0, 2097151) - 32'd1048576) & ~32'd1;
          default: v = $urandom & 32'hFFFF_F000;
        endcase
        send(3'(s), v, 7'($urandom), 5'($urandom), 3'($urandom),
             5'($urandom), 5'($urandom), 7'd0, 0, 32'd0, 0);
      end
      for (int n = 0; n < 50; n++) begin
        send(3'(s), $urandom | 32'h0000_0801, 7'($urandom), 5'd0, 3'd0,
             5'd0, 5'd0, 7'd0, 0, 32'd0, 0);
      end
    end
    drain();
    chk("final_enc_cnt", {16'd0, o_enc_cnt}, exp_cnt(n_hs));
    chk("final_err_cnt", {16'd0, o_err_cnt}, exp_cnt(n_err_hs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
